sci_ctrl_seq: RTL

Multi-cycle control sequencer for the single-cycle-instruction (SCI) datapath. It accepts one 32-bit MIPS-format instruction at a time, splits it into fields and drives the datapath register-file and ALU controls through DECODE/EXEC/MEM/WB states. It also arbitrates the register-file write port between the datapath and an external loader, which preloads registers before a run. It sits between the instruction source (bench or fetch unit) and the existing datapath top (`wrEnable`/`wrReg`/`rdReg1`/`imme`/`opCode`/`selCh`/`selData` inputs).

---
 rtl/sci_pkg.sv | 29 ++
 rtl/sci_ctrl_seq_if.sv | 48 ++++
 rtl/sci_decode.sv | 52 +++++
 rtl/sci_ctrl_seq.sv | 138 +++++++++++++
 4 files changed

// File: rtl/sci_pkg.sv
// Shared encodings for the SCI control sequencer: opcodes, functs, ALU ops and FSM states.
package sci_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam int unsigned ALU_ADD = 0;
   localparam int unsigned ALU_SUB = 1;
   localparam int unsigned ALU_AND = 2;
   localparam int unsigned ALU_OR  = 3;
   localparam int unsigned ALU_SLT = 4;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      EXEC,
      MEM,
      WB
   } seqStateT;

endpackage

// File: rtl/sci_ctrl_seq_if.sv
// Instruction/loader handshake and datapath control bundle of the SCI sequencer.
// Loader signals exist only when SCI_CTRL_LOADER_EN is defined.
interface sci_ctrl_seq_if #(parameter int ALU_OP_W = 4);
   logic                inst_valid;
   logic [31:0]         inst;
   logic                inst_ready;
`ifdef SCI_CTRL_LOADER_EN
   logic                ld_wr_en;
   logic [4:0]          ld_wr_reg;
   logic [31:0]         ld_wr_data;
   logic                ld_wr_ack;
`endif
   logic [4:0]          rd_reg1;
   logic [4:0]          rd_reg2;
   logic [15:0]         imme;
   logic [5:0]          op_code;
   logic [ALU_OP_W-1:0] alu_op;
   logic                alu_src_imm;
   logic                mem_rd;
   logic                mem_wr;
   logic                wr_en;
   logic [4:0]          wr_reg;
   logic                sel_ch;
   logic [31:0]         sel_data;
   logic                busy;
   logic                done;
   logic                illegal;

   modport master (
      output inst_valid, inst,
      input  inst_ready, rd_reg1, rd_reg2, imme, op_code, alu_op, alu_src_imm,
             mem_rd, mem_wr, wr_en, wr_reg, sel_ch, sel_data, busy, done, illegal
`ifdef SCI_CTRL_LOADER_EN
      , output ld_wr_en, ld_wr_reg, ld_wr_data
      , input  ld_wr_ack
`endif
   );

   modport slave (
      input  inst_valid, inst,
      output inst_ready, rd_reg1, rd_reg2, imme, op_code, alu_op, alu_src_imm,
             mem_rd, mem_wr, wr_en, wr_reg, sel_ch, sel_data, busy, done, illegal
`ifdef SCI_CTRL_LOADER_EN
      , input  ld_wr_en, ld_wr_reg, ld_wr_data
      , output ld_wr_ack
`endif
   );
endinterface

// File: rtl/sci_decode.sv
// Combinational op/funct decoder for the SCI sequencer.
module sci_decode
   import sci_pkg::*;
#(
   parameter int ALU_OP_W = 4
) (
   input  logic [5:0]          op,
   input  logic [5:0]          funct,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                alu_src_imm,
   output logic                is_load,
   output logic                is_store,
   output logic                wr_rt,
   output logic                illegal
);

   always_comb begin
      alu_op      = '0;
      alu_src_imm = 1'b0;
      is_load     = 1'b0;
      is_store    = 1'b0;
      wr_rt       = 1'b0;
      illegal     = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  alu_op = ALU_OP_W'(ALU_ADD);
               FN_SUB:  alu_op = ALU_OP_W'(ALU_SUB);
               FN_AND:  alu_op = ALU_OP_W'(ALU_AND);
               FN_OR:   alu_op = ALU_OP_W'(ALU_OR);
               FN_SLT:  alu_op = ALU_OP_W'(ALU_SLT);
               default: illegal = 1'b1;
            endcase
         end
         OP_ADDI: begin
            alu_src_imm = 1'b1;
            wr_rt       = 1'b1;
         end
         OP_LW: begin
            alu_src_imm = 1'b1;
            wr_rt       = 1'b1;
            is_load     = 1'b1;
         end
         OP_SW: begin
            alu_src_imm = 1'b1;
            is_store    = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/sci_ctrl_seq.sv
// Multi-cycle SCI control sequencer: IDLE/DECODE/EXEC/MEM/WB FSM and register-file write-port mux.
// Define SCI_CTRL_LOADER_EN to add the external loader port and its IDLE-time arbitration.
module sci_ctrl_seq
   import sci_pkg::*;
#(
   parameter int ALU_OP_W = 4
) (
   input logic           clk,
   input logic           rst_n,
   sci_ctrl_seq_if.slave bus
);

   seqStateT            state;
   logic [31:0]         instR;
   logic [31:0]         decInst;
   logic [ALU_OP_W-1:0] decAluOp;
   logic                decAluSrcImm, decIsLoad, decIsStore, decWrRt, decIllegal;
   logic [ALU_OP_W-1:0] aluOpQ;
   logic                aluSrcImmQ, memRdQ, memWrQ, wrEnQ, doneQ, illegalQ;
   logic [4:0]          wrRegQ;
   logic                isIdle, ldAck, instReady;

   assign isIdle = (state == IDLE);

   // In IDLE the live word is decoded so `illegal` can be registered at the accept edge.
   assign decInst = isIdle ? bus.inst : instR;

   sci_decode #(.ALU_OP_W(ALU_OP_W)) uDecode (
      .op          (decInst[31:26]),
      .funct       (decInst[5:0]),
      .alu_op      (decAluOp),
      .alu_src_imm (decAluSrcImm),
      .is_load     (decIsLoad),
      .is_store    (decIsStore),
      .wr_rt       (decWrRt),
      .illegal     (decIllegal)
   );

`ifdef SCI_CTRL_LOADER_EN
   assign ldAck         = isIdle & rst_n & bus.ld_wr_en;
   assign bus.ld_wr_ack = ldAck;
   assign bus.sel_ch    = ldAck;
   assign bus.sel_data  = ldAck ? bus.ld_wr_data : '0;
   assign bus.wr_reg    = ldAck ? bus.ld_wr_reg : wrRegQ;
`else
   assign ldAck         = 1'b0;
   assign bus.sel_ch    = 1'b0;
   assign bus.sel_data  = '0;
   assign bus.wr_reg    = wrRegQ;
`endif

   assign instReady       = isIdle & rst_n & ~ldAck;
   assign bus.inst_ready  = instReady;
   assign bus.wr_en       = wrEnQ | ldAck;
   assign bus.busy        = ~isIdle;
   assign bus.done        = doneQ;
   assign bus.illegal     = illegalQ;
   assign bus.mem_rd      = memRdQ;
   assign bus.mem_wr      = memWrQ;
   assign bus.alu_op      = aluOpQ;
   assign bus.alu_src_imm = aluSrcImmQ;
   assign bus.op_code     = instR[31:26];
   assign bus.rd_reg1     = instR[25:21];
   assign bus.rd_reg2     = instR[20:16];
   assign bus.imme        = instR[15:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         instR      <= '0;
         aluOpQ     <= '0;
         aluSrcImmQ <= 1'b0;
         memRdQ     <= 1'b0;
         memWrQ     <= 1'b0;
         wrEnQ      <= 1'b0;
         wrRegQ     <= '0;
         doneQ      <= 1'b0;
         illegalQ   <= 1'b0;
      end else begin
         memRdQ   <= 1'b0;
         memWrQ   <= 1'b0;
         wrEnQ    <= 1'b0;
         wrRegQ   <= '0;
         doneQ    <= 1'b0;
         illegalQ <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.inst_valid && instReady) begin
                  instR    <= bus.inst;
                  illegalQ <= decIllegal;
                  state    <= DECODE;
               end
            end
            DECODE: begin
               if (decIllegal) begin
                  state <= IDLE;
               end else begin
                  aluOpQ     <= decAluOp;
                  aluSrcImmQ <= decAluSrcImm;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (decIsLoad || decIsStore) begin
                  memRdQ <= decIsLoad;
                  memWrQ <= decIsStore;
                  doneQ  <= decIsStore;
                  state  <= MEM;
               end else begin
                  wrEnQ  <= 1'b1;
                  wrRegQ <= decWrRt ? instR[20:16] : instR[15:11];
                  doneQ  <= 1'b1;
                  state  <= WB;
               end
            end
            MEM: begin
               if (decIsStore) begin
                  aluOpQ     <= '0;
                  aluSrcImmQ <= 1'b0;
                  state      <= IDLE;
               end else begin
                  wrEnQ  <= 1'b1;
                  wrRegQ <= instR[20:16];
                  doneQ  <= 1'b1;
                  state  <= WB;
               end
            end
            WB: begin
               aluOpQ     <= '0;
               aluSrcImmQ <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
